// File: rtl/mesh_terminal_adapter.sv
// Terminal adapter between one device and one mesh port: show-ahead TX/RX FIFOs plus a
// two-state pop FSM. Define MESH_TERM_ADDR_CHECK_EN to build the destination address checker.
module mesh_terminal_adapter #(
  parameter int unsigned pkg_sz     = 40,
  parameter int unsigned fifo_depth = 4,
  parameter int unsigned ROW_ID     = 0,
  parameter int unsigned COL_ID     = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [pkg_sz-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [pkg_sz-1:0] data_out_i_in,
  output logic              pndng_i_in,
  input  logic              popin,
  input  logic [pkg_sz-1:0] data_out,
  input  logic              pndng,
  output logic              pop,
  output logic [pkg_sz-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [15:0]       tx_count,
  output logic [15:0]       rx_count,
  output logic [7:0]        misroute_cnt,
  output logic              misroute_err
);

  localparam int unsigned AW = $clog2(fifo_depth);
  localparam logic [pkg_sz-1:0] JumpMask = {8'h00, {(pkg_sz-8){1'b1}}};

  typedef logic [AW:0] ptr_t;
  typedef enum logic {StIdle, StPop} rx_state_e;

  // TX FIFO
  logic [pkg_sz-1:0] tx_mem_q [fifo_depth];
  ptr_t              tx_wr_q, tx_rd_q;
  logic              tx_empty, tx_full, tx_push, tx_pop;

  assign tx_empty      = (tx_wr_q == tx_rd_q);
  assign tx_full       = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
  assign tx_ready      = !tx_full;
  assign pndng_i_in    = !tx_empty;
  assign data_out_i_in = tx_mem_q[tx_rd_q[AW-1:0]];
  assign tx_push       = tx_valid && !tx_full;
  assign tx_pop        = popin && !tx_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_count <= '0;
      for (int i = 0; i < int'(fifo_depth); i++) tx_mem_q[i] <= '0;
    end else begin
      if (tx_push) begin
        // nxt_jump is cleared on entry so the mesh starts routing from zero hops
        tx_mem_q[tx_wr_q[AW-1:0]] <= tx_data & JumpMask;
        tx_wr_q                   <= tx_wr_q + ptr_t'(1);
      end
      if (tx_pop) begin
        tx_rd_q  <= tx_rd_q + ptr_t'(1);
        tx_count <= tx_count + 16'd1;
      end
    end
  end

  // RX FIFO and pop FSM
  logic [pkg_sz-1:0] rx_mem_q [fifo_depth];
  ptr_t              rx_wr_q, rx_rd_q;
  logic              rx_empty, rx_full, rx_capture, rx_pop;
  rx_state_e         state_q, state_d;

  assign rx_empty   = (rx_wr_q == rx_rd_q);
  assign rx_full    = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
  assign rx_valid   = !rx_empty;
  assign rx_data    = rx_mem_q[rx_rd_q[AW-1:0]];
  assign rx_pop     = rx_valid && rx_ready;
  assign rx_capture = (state_q == StPop);

  // Captures only land from StPop, so in StIdle the occupancy already includes every
  // in-flight packet; a concurrent read is deliberately not counted as freeing a slot.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: if (pndng && !rx_full) state_d = StPop;
      StPop: begin
        pop     = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_count <= '0;
      for (int i = 0; i < int'(fifo_depth); i++) rx_mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (rx_capture) begin
        rx_mem_q[rx_wr_q[AW-1:0]] <= data_out;
        rx_wr_q                   <= rx_wr_q + ptr_t'(1);
        rx_count                  <= rx_count + 16'd1;
      end
      if (rx_pop) rx_rd_q <= rx_rd_q + ptr_t'(1);
    end
  end

`ifdef MESH_TERM_ADDR_CHECK_EN
  logic [7:0] mis_cnt_q;
  logic       mis_err_q;
  logic       misrouted;

  assign misrouted = (data_out[pkg_sz-9:pkg_sz-12] != 4'(ROW_ID)) ||
                     (data_out[pkg_sz-13:pkg_sz-16] != 4'(COL_ID));

  always_ff @(posedge clk) begin
    if (reset) begin
      mis_cnt_q <= '0;
      mis_err_q <= 1'b0;
    end else if (rx_capture && misrouted) begin
      mis_err_q <= 1'b1;
      if (mis_cnt_q != 8'hFF) mis_cnt_q <= mis_cnt_q + 8'd1;
    end
  end

  assign misroute_cnt = mis_cnt_q;
  assign misroute_err = mis_err_q;
`else
  assign misroute_cnt = 8'h00;
  assign misroute_err = 1'b0;
`endif

endmodule

// File: tb/tb_mesh_terminal_adapter.sv
// Self-checking bench for mesh_terminal_adapter: directed scenarios plus random traffic
// against a queue-based model; the bench also plays the mesh side.
module tb_mesh_terminal_adapter;

  localparam int PKG = 40;
  localparam int D   = 4;
  localparam logic [3:0] MY_ROW = 4'd1;
  localparam logic [3:0] MY_COL = 4'd2;
  localparam logic [PKG-1:0] JMASK = 40'h00_FFFF_FFFF;

  logic           clk = 1'b0;
  logic           reset;
  logic [PKG-1:0] tx_data, data_out_i_in, data_out, rx_data;
  logic           tx_valid, tx_ready, pndng_i_in, popin, pndng, pop, rx_valid, rx_ready;
  logic [15:0]    tx_count, rx_count;
  logic [7:0]     misroute_cnt;
  logic           misroute_err;

  always #5 clk = ~clk;

  mesh_terminal_adapter #(
    .pkg_sz    (PKG),
    .fifo_depth(D),
    .ROW_ID    (1),
    .COL_ID    (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .data_out_i_in(data_out_i_in),
    .pndng_i_in   (pndng_i_in),
    .popin        (popin),
    .data_out     (data_out),
    .pndng        (pndng),
    .pop          (pop),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_count     (tx_count),
    .rx_count     (rx_count),
    .misroute_cnt (misroute_cnt),
    .misroute_err (misroute_err)
  );

  // Reference model state
  logic [PKG-1:0] tq[$];
  logic [PKG-1:0] rq[$];
  logic [PKG-1:0] src[$];
  logic [15:0]    m_tx_cnt, m_rx_cnt;
  logic [7:0]     m_mis_cnt;
  logic           m_mis_err;
  logic           exp_pop;
  int             total = 0;
  int             bad = 0;

  function automatic logic [PKG-1:0] mk_pkt(input logic [3:0] r, input logic [3:0] c);
    logic [PKG-1:0] p;
    p[31:0]  = $urandom;
    p[39:32] = 8'($urandom);
    p[31:28] = r;
    p[27:24] = c;
    return p;
  endfunction

  task automatic mesh_drive();
    pndng    = (src.size() != 0);
    data_out = (src.size() != 0) ? src[0] : '0;
  endtask

  // One clock: drive inputs, advance DUT and model, sample #1 after the edge.
  task automatic tick(input logic v, input logic [PKG-1:0] d, input logic pi, input logic rr,
                      input logic rst);
    logic acc, txp, rdo, cap, nxt;
    logic [PKG-1:0] cpkt;
    tx_valid = v;
    tx_data  = d;
    popin    = pi;
    rx_ready = rr;
    reset    = rst;
    acc  = v && (tq.size() < D);
    txp  = pi && (tq.size() > 0);
    rdo  = rr && (rq.size() > 0);
    cap  = exp_pop && (src.size() > 0);
    cpkt = cap ? src[0] : '0;
    nxt  = !exp_pop && (src.size() > 0) && (rq.size() < D);
    @(posedge clk);
    #1;
    if (rst) begin
      tq.delete();
      rq.delete();
      m_tx_cnt  = '0;
      m_rx_cnt  = '0;
      m_mis_cnt = '0;
      m_mis_err = 1'b0;
      exp_pop   = 1'b0;
    end else begin
      if (txp) begin
        void'(tq.pop_front());
        m_tx_cnt = m_tx_cnt + 16'd1;
      end
      if (acc) tq.push_back(d & JMASK);
      if (rdo) void'(rq.pop_front());
      if (cap) begin
        rq.push_back(cpkt);
        void'(src.pop_front());
        m_rx_cnt = m_rx_cnt + 16'd1;
`ifdef MESH_TERM_ADDR_CHECK_EN
        if (cpkt[31:28] != MY_ROW || cpkt[27:24] != MY_COL) begin
          m_mis_err = 1'b1;
          if (m_mis_cnt != 8'hFF) m_mis_cnt = m_mis_cnt + 8'd1;
        end
`endif
      end
      exp_pop = nxt;
    end
    mesh_drive();
  endtask

  task automatic do_reset();
    src.delete();
    tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    logic seen;
    tick(1'b1, mk_pkt(4'd3, 4'd3), 1'b1, 1'b1, 1'b1);
    tick(1'b1, mk_pkt(4'd3, 4'd3), 1'b1, 1'b1, 1'b1);
    total++; if (pop !== 1'b0) begin bad++; $display("FAIL reset_pop: got %b want 0", pop); end
    total++; if (pndng_i_in !== 1'b0) begin bad++; $display("FAIL reset_pndng_i_in: got %b want 0", pndng_i_in); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    total++; if (tx_count !== 16'd0 || rx_count !== 16'd0) begin
      bad++; $display("FAIL reset_counts: got tx=%0d rx=%0d want 0/0", tx_count, rx_count); end
    total++; if (misroute_cnt !== 8'd0 || misroute_err !== 1'b0) begin
      bad++; $display("FAIL reset_misroute: got cnt=%0d err=%b want 0/0", misroute_cnt, misroute_err); end
    total++; if (data_out_i_in !== '0 || rx_data !== '0) begin
      bad++; $display("FAIL reset_data: got tx=%h rx=%h want 0", data_out_i_in, rx_data); end
    // Reset asserted in the cycle pop is high
    do_reset();
    src.push_back(mk_pkt(MY_ROW, MY_COL));
    mesh_drive();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (pop === 1'b1) seen = 1'b1;
      else tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
    end
    total++; if (!seen) begin bad++; $display("FAIL midpop_wait: got no pop want pop within 10 cycles"); end
    tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
    total++; if (rx_valid !== 1'b0 || rx_count !== 16'd0 || pop !== 1'b0) begin
      bad++; $display("FAIL midpop_abort: got valid=%b count=%0d pop=%b want 0/0/0", rx_valid, rx_count, pop); end
  endtask

  task automatic test_tx_fill_drain();
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, PKG'(40'hA1 + i), 1'b0, 1'b0, 1'b0);
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL fill_tx_ready: got %b want 0", tx_ready); end
    tick(1'b1, 40'hA5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (data_out_i_in !== PKG'(40'hA1 + i) || pndng_i_in !== 1'b1) begin
        bad++; $display("FAIL drain_head%0d: got %h/%b want %h/1", i, data_out_i_in, pndng_i_in, 40'hA1 + i);
      end
      tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    total++; if (tx_count !== 16'd4 || pndng_i_in !== 1'b0) begin
      bad++; $display("FAIL drain_end: got count=%0d pndng=%b want 4/0", tx_count, pndng_i_in); end
    tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
    total++; if (tx_count !== 16'd4) begin bad++; $display("FAIL empty_popin: got %0d want 4", tx_count); end
  endtask

  task automatic test_tx_simultaneous();
    logic [PKG-1:0] want [4];
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, PKG'(40'hB1 + i), 1'b0, 1'b0, 1'b0);
    tx_valid = 1'b1; tx_data = 40'hB5; popin = 1'b1;
    #1;
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL full_popin_ready: got %b want 0", tx_ready); end
    tick(1'b1, 40'hB5, 1'b1, 1'b0, 1'b0);
    total++; if (tx_ready !== 1'b1 || data_out_i_in !== 40'hB2) begin
      bad++; $display("FAIL full_both: got ready=%b head=%h want 1/b2", tx_ready, data_out_i_in); end
    tick(1'b1, 40'hB6, 1'b0, 1'b0, 1'b0);
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL occ3_refill: got ready=%b want 0", tx_ready); end
    tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 40'hB7, 1'b1, 1'b0, 1'b0);
    want[0] = 40'hB6; want[1] = 40'hB7;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (data_out_i_in !== want[i] || pndng_i_in !== 1'b1) begin
        bad++; $display("FAIL occ2_order%0d: got %h want %h", i, data_out_i_in, want[i]);
      end
      tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    total++; if (pndng_i_in !== 1'b0) begin bad++; $display("FAIL occ2_empty: got %b want 0", pndng_i_in); end
  endtask

  task automatic test_nxt_jump();
    do_reset();
    tick(1'b1, 40'hFF_12_3A_BCDE, 1'b0, 1'b0, 1'b0);
    total++; if (data_out_i_in !== 40'h00_12_3A_BCDE) begin
      bad++; $display("FAIL nxt_jump_clear: got %h want 00123abcde", data_out_i_in); end
  endtask

  task automatic test_rx_backpressure();
    logic [PKG-1:0] sent[$];
    logic [PKG-1:0] got[$];
    int pops;
    logic prev;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      sent.push_back(mk_pkt(MY_ROW, MY_COL));
      src.push_back(sent[i]);
    end
    mesh_drive();
    pops = 0;
    prev = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
      total++;
      if (pop !== exp_pop || (pop && prev)) begin
        bad++; $display("FAIL bp_pop_cyc%0d: got %b want %b (prev %b)", i, pop, exp_pop, prev);
      end
      if (pop === 1'b1) pops++;
      prev = pop;
    end
    total++; if (pops != 4) begin bad++; $display("FAIL bp_pop_count: got %0d want 4", pops); end
    for (int i = 0; i < 30; i++) begin
      if (rx_valid === 1'b1) got.push_back(rx_data);
      tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
    end
    total++; if (got.size() != 6 || rx_count !== 16'd6) begin
      bad++; $display("FAIL bp_delivered: got %0d/%0d want 6/6", got.size(), rx_count); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      total++;
      if (got[i] !== sent[i]) begin bad++; $display("FAIL bp_order%0d: got %h want %h", i, got[i], sent[i]); end
    end
  endtask

  task automatic test_misroute();
    logic [PKG-1:0] sent[$];
    logic [PKG-1:0] got[$];
    logic [7:0] want_cnt;
    logic want_err;
    do_reset();
    sent.push_back(mk_pkt(4'd1, 4'd2));
    sent.push_back(mk_pkt(4'd3, 4'd0));
    src.push_back(sent[0]);
    src.push_back(sent[1]);
    mesh_drive();
    for (int i = 0; i < 10; i++) begin
      if (rx_valid === 1'b1) got.push_back(rx_data);
      tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
    end
`ifdef MESH_TERM_ADDR_CHECK_EN
    want_cnt = 8'd1; want_err = 1'b1;
`else
    want_cnt = 8'd0; want_err = 1'b0;
`endif
    total++; if (misroute_cnt !== want_cnt || misroute_err !== want_err) begin
      bad++; $display("FAIL misroute_one: got %0d/%b want %0d/%b", misroute_cnt, misroute_err, want_cnt, want_err); end
    total++; if (got.size() != 2 || got[0] !== sent[0] || got[1] !== sent[1]) begin
      bad++; $display("FAIL misroute_delivered: got %0d pkts want 2 in order", got.size()); end
    for (int i = 0; i < 300; i++) src.push_back(mk_pkt(4'd3, 4'(i % 16)));
    mesh_drive();
    for (int i = 0; i < 700; i++) tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
`ifdef MESH_TERM_ADDR_CHECK_EN
    want_cnt = 8'd255;
`endif
    total++; if (misroute_cnt !== want_cnt || misroute_err !== want_err || rx_count !== 16'd302) begin
      bad++; $display("FAIL misroute_sat: got cnt=%0d err=%b rx=%0d want %0d/%b/302",
                      misroute_cnt, misroute_err, rx_count, want_cnt, want_err); end
  endtask

  task automatic test_random();
    logic [3:0] r, c;
    int errs;
    do_reset();
    errs = 0;
    for (int i = 0; i < 2000; i++) begin
      if (src.size() < 3 && $urandom_range(0, 2) == 0) begin
        r = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : MY_ROW;
        c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : MY_COL;
        src.push_back(mk_pkt(r, c));
        mesh_drive();
      end
      tick($urandom_range(0, 1) == 1, mk_pkt(4'($urandom), 4'($urandom)),
           $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, 1'b0);
      total++;
      if (tx_ready !== (tq.size() < D) || pndng_i_in !== (tq.size() != 0)) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rnd_tx_flags cyc%0d: got %b/%b want %b/%b", i, tx_ready,
                                pndng_i_in, tq.size() < D, tq.size() != 0);
      end
      if (tq.size() != 0) begin
        total++;
        if (data_out_i_in !== tq[0]) begin
          bad++; errs++;
          if (errs < 10) $display("FAIL rnd_tx_head cyc%0d: got %h want %h", i, data_out_i_in, tq[0]);
        end
      end
      total++;
      if (rx_valid !== (rq.size() != 0) || pop !== exp_pop) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rnd_rx_flags cyc%0d: got valid=%b pop=%b want %b/%b", i,
                                rx_valid, pop, rq.size() != 0, exp_pop);
      end
      if (rq.size() != 0) begin
        total++;
        if (rx_data !== rq[0]) begin
          bad++; errs++;
          if (errs < 10) $display("FAIL rnd_rx_head cyc%0d: got %h want %h", i, rx_data, rq[0]);
        end
      end
      total++;
      if (tx_count !== m_tx_cnt || rx_count !== m_rx_cnt || misroute_cnt !== m_mis_cnt ||
          misroute_err !== m_mis_err) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rnd_counters cyc%0d: got %0d/%0d/%0d/%b want %0d/%0d/%0d/%b",
                                i, tx_count, rx_count, misroute_cnt, misroute_err,
                                m_tx_cnt, m_rx_cnt, m_mis_cnt, m_mis_err);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    popin    = 1'b0;
    rx_ready = 1'b0;
    pndng    = 1'b0;
    data_out = '0;
    exp_pop  = 1'b0;
    m_tx_cnt = '0;
    m_rx_cnt = '0;
    m_mis_cnt = '0;
    m_mis_err = 1'b0;
    test_reset();
    test_tx_fill_drain();
    test_tx_simultaneous();
    test_nxt_jump();
    test_rx_backpressure();
    test_misroute();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
